// File: rtl/glitch_sequencer_if.sv
// glitch_sequencer_if: host config/strobe inputs and glitch_core-facing outputs of the glitch sequencer.
interface glitch_sequencer_if #(
   parameter int DELAY_W = 32,
   parameter int WIDTH_W = 16,
   parameter int COUNT_W = 8
);
   logic [DELAY_W-1:0] cfg_delay;
   logic [WIDTH_W-1:0] cfg_width;
   logic [WIDTH_W-1:0] cfg_gap;
   logic [COUNT_W-1:0] cfg_count;
   logic [7:0]         cfg_mode;
   logic               arm;
   logic               abort;
   logic               trigger;
   logic               glitch_en;
   logic [7:0]         glitch_mode;
   logic               armed;
   logic               busy;
   logic               done;
   modport master (
      output cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode, arm, abort, trigger,
      input  glitch_en, glitch_mode, armed, busy, done
   );
   modport slave (
      input  cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode, arm, abort, trigger,
      output glitch_en, glitch_mode, armed, busy, done
   );
endinterface

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arms on a host strobe, waits for a synchronised trigger rise, then drives
// glitch_core with a programmable delay followed by a burst of pulses.
module glitch_sequencer #(
   parameter int DELAY_W = 32,
   parameter int WIDTH_W = 16,
   parameter int COUNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   glitch_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP, DONE} state_t;
   state_t state_q, state_d;
   logic s1_q, s2_q, s3_q, edge_q;
   logic [DELAY_W-1:0] delay_q, delay_d, cnt_q, cnt_d;
   logic [WIDTH_W-1:0] width_q, width_d, gap_q, gap_d;
   logic [COUNT_W-1:0] count_q, count_d, pcnt_q, pcnt_d;
   logic [7:0] mode_q, mode_d;
   logic en_q, en_d;
   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      width_d = width_q;
      gap_d   = gap_q;
      count_d = count_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: if (bus.arm) begin
            state_d = ARMED;
            delay_d = bus.cfg_delay;
            width_d = (bus.cfg_width == '0) ? WIDTH_W'(1) : bus.cfg_width;
            gap_d   = (bus.cfg_gap == '0) ? WIDTH_W'(1) : bus.cfg_gap;
            count_d = (bus.cfg_count == '0) ? COUNT_W'(1) : bus.cfg_count;
            mode_d  = bus.cfg_mode;
         end
         ARMED: if (edge_q) begin
            pcnt_d  = count_q;
            state_d = (delay_q == '0) ? PULSE : DELAY;
            cnt_d   = (delay_q == '0) ? DELAY_W'(width_q) : delay_q;
         end
         DELAY: begin
            state_d = (cnt_q == DELAY_W'(1)) ? PULSE : DELAY;
            cnt_d   = (cnt_q == DELAY_W'(1)) ? DELAY_W'(width_q) : cnt_q - DELAY_W'(1);
         end
         PULSE: if (cnt_q == DELAY_W'(1)) begin
            state_d = (pcnt_q == COUNT_W'(1)) ? DONE : GAP;
            cnt_d   = (pcnt_q == COUNT_W'(1)) ? '0 : DELAY_W'(gap_q);
            pcnt_d  = pcnt_q - COUNT_W'(1);
         end else
            cnt_d = cnt_q - DELAY_W'(1);
         GAP: begin
            state_d = (cnt_q == DELAY_W'(1)) ? PULSE : GAP;
            cnt_d   = (cnt_q == DELAY_W'(1)) ? DELAY_W'(width_q) : cnt_q - DELAY_W'(1);
         end
         default: state_d = IDLE;
      endcase
      // abort overrides everything, including an arm in the same cycle
      if (bus.abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         pcnt_d  = '0;
      end
      if (state_d == IDLE) mode_d = 8'h00;
      en_d = (state_d == PULSE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         edge_q  <= 1'b0;
         delay_q <= '0;
         width_q <= '0;
         gap_q   <= '0;
         count_q <= '0;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         mode_q  <= 8'h00;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= bus.trigger;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         edge_q  <= s2_q & ~s3_q;
         delay_q <= delay_d;
         width_q <= width_d;
         gap_q   <= gap_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         mode_q  <= mode_d;
         en_q    <= en_d;
      end
   end
   assign bus.glitch_en   = en_q;
   assign bus.glitch_mode = mode_q;
   assign bus.armed       = (state_q == ARMED);
   assign bus.busy        = (state_q == DELAY) || (state_q == PULSE) || (state_q == GAP);
   assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: randomized bursts checked cycle-by-cycle against an arithmetic timeline model.
module tb_glitch_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   glitch_sequencer_if #(.DELAY_W(32), .WIDTH_W(16), .COUNT_W(8)) bus ();
   glitch_sequencer #(.DELAY_W(32), .WIDTH_W(16), .COUNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   task automatic do_arm();
      @(negedge clk);
      bus.arm = 1'b1;
      @(negedge clk);
      bus.arm = 1'b0;
   endtask
   // Model: pulse i occupies edges [first+i*(w+g), first+i*(w+g)+w); done at the edge after the last pulse.
   task automatic fire_check(input int d, input int w, input int g, input int n, input logic [7:0] m,
                             input bit rearm, input string name);
      int we, ge, ne, k, first, done_t, off, t;
      logic exp_en;
      we = (w == 0) ? 1 : w;
      ge = (g == 0) ? 1 : g;
      ne = (n == 0) ? 1 : n;
      @(negedge clk);
      bus.trigger = 1'b1;
      k = cyc + 1;
      first = k + 3 + d;
      done_t = first + ne * we + (ne - 1) * ge;
      do begin
         @(posedge clk);
         #1;
         t = cyc;
         off = t - first;
         exp_en = (t >= first) && (off / (we + ge) < ne) && (off % (we + ge) < we);
         n_checks++;
         if (bus.glitch_en !== exp_en) begin
            n_fail++;
            $display("FAIL %s en t=%0d: got %b want %b", name, t - k, bus.glitch_en, exp_en);
         end
         n_checks++;
         if (bus.done !== (t == done_t)) begin
            n_fail++;
            $display("FAIL %s done t=%0d: got %b want %b", name, t - k, bus.done, t == done_t);
         end
         n_checks++;
         if (bus.busy !== (t >= k + 3 && t < done_t)) begin
            n_fail++;
            $display("FAIL %s busy t=%0d: got %b want %b", name, t - k, bus.busy, t >= k + 3 && t < done_t);
         end
         n_checks++;
         if (bus.armed !== (t < k + 3)) begin
            n_fail++;
            $display("FAIL %s armed t=%0d: got %b want %b", name, t - k, bus.armed, t < k + 3);
         end
         n_checks++;
         if (bus.glitch_mode !== ((t <= done_t) ? m : 8'h00)) begin
            n_fail++;
            $display("FAIL %s mode t=%0d: got %h want %h", name, t - k, bus.glitch_mode, (t <= done_t) ? m : 8'h00);
         end
         if (rearm) bus.arm = (t == first);
      end while (t < done_t + 2);
      bus.arm = 1'b0;
      bus.trigger = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic burst_check(input int d, input int w, input int g, input int n, input logic [7:0] m,
                              input string name);
      bus.cfg_delay = 32'(d);
      bus.cfg_width = 16'(w);
      bus.cfg_gap   = 16'(g);
      bus.cfg_count = 8'(n);
      bus.cfg_mode  = m;
      do_arm();
      n_checks++;
      if (bus.armed !== 1'b1) begin
         n_fail++;
         $display("FAIL %s armed_after_arm: got %b want 1", name, bus.armed);
      end
      bus.cfg_delay = $urandom;
      bus.cfg_width = 16'($urandom);
      bus.cfg_gap   = 16'($urandom);
      bus.cfg_count = 8'($urandom);
      bus.cfg_mode  = 8'($urandom);
      repeat (2) @(negedge clk);
      fire_check(d, w, g, n, m, 1'b0, name);
   endtask
   task automatic test_reset();
      bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_count = '0; bus.cfg_mode = '0;
      bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger = 1'b0;
      #3;
      n_checks++;
      if ({bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset outputs: got en=%b mode=%h armed=%b busy=%b done=%b want all 0",
                  bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.glitch_en, bus.armed, bus.busy, bus.done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got en=%b armed=%b busy=%b done=%b want 0",
                  bus.glitch_en, bus.armed, bus.busy, bus.done);
      end
   endtask
   task automatic test_basic();
      burst_check(0, 1, 1, 1, 8'hA7, "single");
      burst_check(10, 3, 2, 3, 8'h3C, "multi");
      burst_check(0, 0, 0, 0, 8'h81, "zeros");
   endtask
   task automatic test_random();
      for (int i = 0; i < 8; i++)
         burst_check(int'($urandom_range(0, 20)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 4)), 8'($urandom_range(1, 255)), "random");
   endtask
   task automatic test_trigger_held();
      bus.trigger = 1'b1;
      repeat (5) @(negedge clk);
      bus.cfg_delay = 32'd2; bus.cfg_width = 16'd2; bus.cfg_gap = 16'd1; bus.cfg_count = 8'd2;
      bus.cfg_mode = 8'h5E;
      do_arm();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.glitch_en !== 1'b0 || bus.armed !== 1'b1) begin
            n_fail++;
            $display("FAIL held_trigger cyc %0d: got en=%b armed=%b want en=0 armed=1", i, bus.glitch_en, bus.armed);
         end
      end
      bus.trigger = 1'b0;
      repeat (3) @(negedge clk);
      fire_check(2, 2, 1, 2, 8'h5E, 1'b1, "held_refire");
   endtask
   task automatic test_abort();
      int k;
      bus.cfg_delay = 32'd0; bus.cfg_width = 16'd5; bus.cfg_gap = 16'd1; bus.cfg_count = 8'd1;
      bus.cfg_mode = 8'h5A;
      do_arm();
      @(negedge clk);
      bus.trigger = 1'b1;
      k = cyc + 1;
      while (cyc < k + 4) @(posedge clk);
      #1;
      n_checks++;
      if (bus.glitch_en !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre en: got %b want 1", bus.glitch_en);
      end
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      n_checks++;
      if ({bus.glitch_en, bus.armed, bus.busy, bus.done, bus.glitch_mode} !== 12'h000) begin
         n_fail++;
         $display("FAIL abort_post: got en=%b armed=%b busy=%b done=%b mode=%h want all 0",
                  bus.glitch_en, bus.armed, bus.busy, bus.done, bus.glitch_mode);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.done !== 1'b0 || bus.glitch_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet cyc %0d: got done=%b en=%b want 0", i, bus.done, bus.glitch_en);
         end
      end
      bus.trigger = 1'b0;
      repeat (3) @(negedge clk);
      bus.arm = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.arm = 1'b0;
      bus.abort = 1'b0;
      n_checks++;
      if (bus.armed !== 1'b0) begin
         n_fail++;
         $display("FAIL arm_abort armed: got %b want 0", bus.armed);
      end
      bus.trigger = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.glitch_en !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_abort fire cyc %0d: got en=%b busy=%b want 0", i, bus.glitch_en, bus.busy);
         end
      end
      bus.trigger = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic test_async_reset();
      int k;
      bus.cfg_delay = 32'd2; bus.cfg_width = 16'd2; bus.cfg_gap = 16'd4; bus.cfg_count = 8'd2;
      bus.cfg_mode = 8'hC3;
      do_arm();
      @(negedge clk);
      bus.trigger = 1'b1;
      k = cyc + 1;
      while (cyc < k + 3 + 2 + 2 + 1) @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.glitch_en !== 1'b0) begin
         n_fail++;
         $display("FAIL in_gap: got busy=%b en=%b want busy=1 en=0", bus.busy, bus.glitch_en);
      end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done} !== 12'h000) begin
         n_fail++;
         $display("FAIL async_reset: got en=%b mode=%h armed=%b busy=%b done=%b want all 0",
                  bus.glitch_en, bus.glitch_mode, bus.armed, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.trigger = 1'b0;
      repeat (4) @(negedge clk);
      burst_check(3, 2, 1, 2, 8'h69, "after_reset");
   endtask
   initial begin
      test_reset();
      test_basic();
      test_random();
      test_trigger_held();
      test_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
